// File: rtl/muldiv_iter_pkg.sv
// Shared types for the iterative multiply/divide unit: operation codes,
// FSM state encoding and a small operation classifier.
package muldiv_iter_pkg;

   typedef enum logic [2:0] {
      OP_MUL  = 3'd0,
      OP_MADD = 3'd1,
      OP_MSUB = 3'd2,
      OP_DIV  = 3'd3,
      OP_MTHI = 3'd4,
      OP_MTLO = 3'd5
   } muldiv_op_t;

   typedef enum logic [1:0] {
      MD_IDLE,
      MD_MUL,
      MD_DIV,
      MD_FIX
   } muldiv_state_t;

   function automatic logic is_mul_op(muldiv_op_t op);
      return op inside {OP_MUL, OP_MADD, OP_MSUB};
   endfunction

endpackage

// File: rtl/muldiv_iter_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
interface muldiv_iter_if
   import muldiv_iter_pkg::*;
#(
   parameter int WIDTH = 32
);
   logic             req_valid;
   logic             req_ready;
   muldiv_op_t       req_op;
   logic             req_u;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             flush;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             div_by_zero;

   modport master (
      output req_valid, req_op, req_u, a, b, flush,
      input  req_ready, busy, done, hi, lo, div_by_zero
   );

   modport slave (
      input  req_valid, req_op, req_u, a, b, flush,
      output req_ready, busy, done, hi, lo, div_by_zero
   );
endinterface

// File: rtl/muldiv_div_step.sv
// Combinational restoring-division step retiring DIV_BITS quotient bits.
// Dividend bits enter MSB first; the partial remainder always stays below the divisor.
module muldiv_div_step #(
   parameter int WIDTH    = 32,
   parameter int DIV_BITS = 1
) (
   input  logic [WIDTH-1:0]    rem_in,
   input  logic [DIV_BITS-1:0] dvd_bits,
   input  logic [WIDTH-1:0]    divisor,
   output logic [WIDTH-1:0]    rem_out,
   output logic [DIV_BITS-1:0] q_bits
);
   logic [WIDTH-1:0] rem_chain [DIV_BITS+1];

   assign rem_chain[0] = rem_in;

   for (genvar gi = 0; gi < DIV_BITS; gi++) begin : g_stage
      logic [WIDTH:0] trial;
      logic           fits;
      assign trial = {rem_chain[gi], dvd_bits[DIV_BITS-1-gi]};
      assign fits  = trial >= {1'b0, divisor};
      assign q_bits[DIV_BITS-1-gi] = fits;
      assign rem_chain[gi+1] = fits ? WIDTH'(trial - {1'b0, divisor}) : trial[WIDTH-1:0];
   end

   assign rem_out = rem_chain[DIV_BITS];
endmodule

// File: rtl/muldiv_iter.sv
// Iterative MUL/MADD/MSUB/DIV unit owning HI/LO. Operates on magnitudes and
// applies sign correction and accumulation in a single FIX cycle.
module muldiv_iter
   import muldiv_iter_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int MUL_BITS = 2,
   parameter int DIV_BITS = 1
) (
   input logic          clock,
   input logic          reset_n,
   muldiv_iter_if.slave bus
);
   localparam int MUL_ITERS = WIDTH / MUL_BITS;
   localparam int DIV_ITERS = WIDTH / DIV_BITS;
   localparam int CW        = $clog2(WIDTH) + 1;

   muldiv_state_t      state_reg, state_next;
   logic [CW-1:0]      cnt_reg, cnt_next;
   muldiv_op_t         op_reg;
   logic [WIDTH-1:0]   mcand_reg, divisor_reg, rem_reg, quo_reg, hi_reg, lo_reg;
   logic [2*WIDTH-1:0] prod_reg;
   logic               neg_q_reg, neg_r_reg, dbz_reg;

   logic               accept, done_int, sign_a, sign_b;
   logic [WIDTH-1:0]   mag_a, mag_b;

   assign accept = bus.req_valid && (state_reg == MD_IDLE) && !bus.flush;
   assign sign_a = !bus.req_u && bus.a[WIDTH-1];
   assign sign_b = !bus.req_u && bus.b[WIDTH-1];
   assign mag_a  = sign_a ? -bus.a : bus.a;
   assign mag_b  = sign_b ? -bus.b : bus.b;

   // Shift-add: low half of prod_reg starts as the multiplier and drains out.
   logic [WIDTH+MUL_BITS-1:0] pp_term [MUL_BITS];
   logic [WIDTH+MUL_BITS-1:0] pp_sum;
   logic [2*WIDTH-1:0]        prod_step;

   for (genvar gi = 0; gi < MUL_BITS; gi++) begin : g_pp
      assign pp_term[gi] = prod_reg[gi] ? ({{MUL_BITS{1'b0}}, mcand_reg} << gi) : '0;
   end

   always_comb begin
      pp_sum = {{MUL_BITS{1'b0}}, prod_reg[2*WIDTH-1:WIDTH]};
      for (int j = 0; j < MUL_BITS; j++) begin
         pp_sum = pp_sum + pp_term[j];
      end
   end

   assign prod_step = {pp_sum, prod_reg[WIDTH-1:MUL_BITS]};

   logic [WIDTH-1:0]    rem_step;
   logic [DIV_BITS-1:0] q_bits;

   muldiv_div_step #(.WIDTH(WIDTH), .DIV_BITS(DIV_BITS)) u_div_step (
      .rem_in   (rem_reg),
      .dvd_bits (quo_reg[WIDTH-1 -: DIV_BITS]),
      .divisor  (divisor_reg),
      .rem_out  (rem_step),
      .q_bits   (q_bits)
   );

   logic [2*WIDTH-1:0] prod_signed, hilo_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix;

   always_comb begin
      prod_signed = neg_q_reg ? -prod_reg : prod_reg;
      quo_fix     = neg_q_reg ? -quo_reg : quo_reg;
      rem_fix     = neg_r_reg ? -rem_reg : rem_reg;
      case (op_reg)
         OP_MADD: hilo_fix = {hi_reg, lo_reg} + prod_signed;
         OP_MSUB: hilo_fix = {hi_reg, lo_reg} - prod_signed;
         OP_DIV:  hilo_fix = {rem_fix, dbz_reg ? {WIDTH{1'b1}} : quo_fix};
         default: hilo_fix = prod_signed;
      endcase
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         MD_IDLE: begin
            if (accept && is_mul_op(bus.req_op)) begin
               state_next = MD_MUL;
            end else if (accept && bus.req_op == OP_DIV) begin
               state_next = MD_DIV;
            end
         end
         MD_MUL: begin
            cnt_next = cnt_reg + CW'(1);
            if (cnt_reg == CW'(MUL_ITERS - 1)) begin
               state_next = MD_FIX;
               cnt_next   = '0;
            end
         end
         MD_DIV: begin
            cnt_next = cnt_reg + CW'(1);
            if (cnt_reg == CW'(DIV_ITERS - 1)) begin
               state_next = MD_FIX;
               cnt_next   = '0;
            end
         end
         default: state_next = MD_IDLE;
      endcase
      if (bus.flush) begin
         state_next = MD_IDLE;
         cnt_next   = '0;
      end
   end

   assign done_int        = (state_reg == MD_FIX) && !bus.flush;
   assign bus.done        = done_int;
   assign bus.busy        = (state_reg != MD_IDLE);
   assign bus.req_ready   = (state_reg == MD_IDLE);
   assign bus.hi          = hi_reg;
   assign bus.lo          = lo_reg;
   assign bus.div_by_zero = dbz_reg;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_reg   <= MD_IDLE;
         cnt_reg     <= '0;
         op_reg      <= OP_MUL;
         mcand_reg   <= '0;
         divisor_reg <= '0;
         rem_reg     <= '0;
         quo_reg     <= '0;
         prod_reg    <= '0;
         hi_reg      <= '0;
         lo_reg      <= '0;
         neg_q_reg   <= 1'b0;
         neg_r_reg   <= 1'b0;
         dbz_reg     <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         if (accept) begin
            case (bus.req_op)
               OP_MTHI: hi_reg <= bus.a;
               OP_MTLO: lo_reg <= bus.a;
               default: begin
                  op_reg      <= bus.req_op;
                  mcand_reg   <= mag_a;
                  divisor_reg <= mag_b;
                  prod_reg    <= {{WIDTH{1'b0}}, mag_b};
                  quo_reg     <= mag_a;
                  rem_reg     <= '0;
                  neg_q_reg   <= sign_a ^ sign_b;
                  neg_r_reg   <= sign_a;
                  if (bus.req_op == OP_DIV) begin
                     dbz_reg <= (bus.b == '0);
                  end
               end
            endcase
         end
         if (state_reg == MD_MUL) begin
            prod_reg <= prod_step;
         end
         if (state_reg == MD_DIV) begin
            rem_reg <= rem_step;
            quo_reg <= {quo_reg[WIDTH-DIV_BITS-1:0], q_bits};
         end
         if (done_int) begin
            {hi_reg, lo_reg} <= hilo_fix;
         end
      end
   end
endmodule

// File: tb/tb_muldiv_iter.sv
// Randomised scoreboard bench for muldiv_iter against a plain-arithmetic HI/LO model.
module tb_muldiv_iter;
   import muldiv_iter_pkg::*;

   localparam int W       = 32;
   localparam int MUL_LAT = W / 2 + 1;
   localparam int DIV_LAT = W / 1 + 1;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;
   int   checks  = 0;
   int   errors  = 0;
   int   cycle   = 0;

   logic [W-1:0] hi_m  = '0;
   logic [W-1:0] lo_m  = '0;
   logic         dbz_m = 1'b0;

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dbz;
      int           lat;
      int           t0;
      string        name;
   } exp_t;
   exp_t exp_q[$];

   muldiv_iter_if #(.WIDTH(W)) bus ();

   muldiv_iter #(.WIDTH(W), .MUL_BITS(2), .DIV_BITS(1)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cycle <= cycle + 1;

   function automatic void check(string name, logic [63:0] act, logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endfunction

   // Reference: architectural HI/LO semantics in plain 64-bit arithmetic.
   function automatic void model(muldiv_op_t op, logic u, logic [W-1:0] a, logic [W-1:0] b);
      logic [63:0] p;
      longint      q, r;
      if (u) p = {32'b0, a} * {32'b0, b};
      else   p = longint'($signed(a)) * longint'($signed(b));
      case (op)
         OP_MUL:  {hi_m, lo_m} = p;
         OP_MADD: {hi_m, lo_m} = {hi_m, lo_m} + p;
         OP_MSUB: {hi_m, lo_m} = {hi_m, lo_m} - p;
         OP_DIV: begin
            dbz_m = (b == '0);
            if (b == '0) begin
               lo_m = '1;
               hi_m = a;
            end else if (u) begin
               lo_m = a / b;
               hi_m = a % b;
            end else begin
               q = longint'($signed(a)) / longint'($signed(b));
               r = longint'($signed(a)) % longint'($signed(b));
               lo_m = 32'(q);
               hi_m = 32'(r);
            end
         end
         OP_MTHI: hi_m = a;
         OP_MTLO: lo_m = a;
         default: ;
      endcase
   endfunction

   task automatic issue(muldiv_op_t op, logic u, logic [W-1:0] a, logic [W-1:0] b, string name);
      int   n;
      exp_t e;
      n = 0;
      @(negedge clock);
      while (!bus.req_ready && n < 300) begin
         @(negedge clock);
         n++;
      end
      if (!bus.req_ready) begin
         check({name, "_ready_timeout"}, 64'(bus.req_ready), 64'd1);
         return;
      end
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_u     = u;
      bus.a         = a;
      bus.b         = b;
      @(posedge clock);
      #1;
      bus.req_valid = 1'b0;
      bus.a         = $urandom;
      bus.b         = $urandom;
      bus.req_u     = 1'($urandom);
      model(op, u, a, b);
      if (op == OP_MTHI || op == OP_MTLO) begin
         check({name, "_hi"}, 64'(bus.hi), 64'(hi_m));
         check({name, "_lo"}, 64'(bus.lo), 64'(lo_m));
         check({name, "_busy"}, 64'(bus.busy), 64'd0);
         $display("txn %s %s a=%h hi=%h lo=%h", name, op.name(), a, bus.hi, bus.lo);
      end else begin
         check({name, "_busy"}, 64'(bus.busy), 64'd1);
         e.hi   = hi_m;
         e.lo   = lo_m;
         e.dbz  = dbz_m;
         e.lat  = (op == OP_DIV) ? DIV_LAT : MUL_LAT;
         e.t0   = cycle;
         e.name = name;
         exp_q.push_back(e);
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() > 0 && n < 500) begin
         @(negedge clock);
         n++;
      end
      check("pending_results", 64'(exp_q.size()), 64'd0);
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 7))
         0:       return '0;
         1:       return '1;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(0, 9));
         default: return $urandom;
      endcase
   endfunction

   // Monitor: every done pulse retires the oldest expected result.
   initial begin
      forever begin
         @(negedge clock);
         if (reset_n && bus.done) begin
            @(posedge clock);
            #1;
            if (exp_q.size() == 0) begin
               check("unexpected_done", 64'd1, 64'd0);
            end else begin : retire
               exp_t e;
               e = exp_q.pop_front();
               check({e.name, "_hi"}, 64'(bus.hi), 64'(e.hi));
               check({e.name, "_lo"}, 64'(bus.lo), 64'(e.lo));
               check({e.name, "_dbz"}, 64'(bus.div_by_zero), 64'(e.dbz));
               check({e.name, "_latency"}, 64'(cycle - e.t0), 64'(e.lat));
               $display("txn %s hi=%h lo=%h dbz=%0d lat=%0d", e.name, bus.hi, bus.lo,
                        bus.div_by_zero, cycle - e.t0);
            end
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.req_valid = 1'b0;
      bus.flush     = 1'b0;
      bus.req_op    = OP_MUL;
      bus.req_u     = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      repeat (3) @(negedge clock);
      check("rst_hi", 64'(bus.hi), 64'd0);
      check("rst_lo", 64'(bus.lo), 64'd0);
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_done", 64'(bus.done), 64'd0);
      check("rst_dbz", 64'(bus.div_by_zero), 64'd0);
      check("rst_ready", 64'(bus.req_ready), 64'd1);
      reset_n = 1'b1;

      issue(OP_MUL, 1'b0, 32'hFFFF_FFFD, 32'd7, "mul_s_m3x7");
      issue(OP_MTHI, 1'b0, 32'd0, 32'd0, "mthi0");
      issue(OP_MTLO, 1'b0, 32'd10, 32'd0, "mtlo10");
      issue(OP_MADD, 1'b1, 32'hFFFF_FFFF, 32'd2, "madd_u");
      issue(OP_MSUB, 1'b1, 32'hFFFF_FFFF, 32'd2, "msub_u");
      issue(OP_DIV, 1'b0, 32'hFFFF_FFF9, 32'd2, "div_s_m7d2");
      issue(OP_DIV, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, "div_s_min_m1");
      issue(OP_DIV, 1'b1, 32'd5, 32'd0, "div_u_5d0");
      issue(OP_DIV, 1'b1, 32'd6, 32'd3, "div_u_6d3");
      drain();

      // Flush mid-MUL: no done, HI/LO untouched, ready again next cycle.
      issue(OP_MTHI, 1'b0, 32'd9, 32'd0, "mthi9");
      issue(OP_MTLO, 1'b0, 32'd9, 32'd0, "mtlo9");
      @(negedge clock);
      bus.req_valid = 1'b1;
      bus.req_op    = OP_MUL;
      bus.req_u     = 1'b1;
      bus.a         = 32'd5;
      bus.b         = 32'd5;
      @(posedge clock);
      #1;
      bus.req_valid = 1'b0;
      repeat (5) @(negedge clock);
      bus.flush = 1'b1;
      @(posedge clock);
      #1;
      bus.flush = 1'b0;
      check("flush_busy", 64'(bus.busy), 64'd0);
      check("flush_ready", 64'(bus.req_ready), 64'd1);
      repeat (20) @(negedge clock);
      check("flush_hi", 64'(bus.hi), 64'd9);
      check("flush_lo", 64'(bus.lo), 64'd9);

      // Flush in the accept cycle cancels the request.
      @(negedge clock);
      bus.req_valid = 1'b1;
      bus.req_op    = OP_MTLO;
      bus.a         = 32'h1234;
      bus.flush     = 1'b1;
      @(posedge clock);
      #1;
      bus.req_valid = 1'b0;
      bus.flush     = 1'b0;
      check("flush_mtlo_lo", 64'(bus.lo), 64'd9);
      @(negedge clock);
      bus.req_valid = 1'b1;
      bus.req_op    = OP_MUL;
      bus.a         = 32'd3;
      bus.b         = 32'd3;
      bus.flush     = 1'b1;
      @(posedge clock);
      #1;
      bus.req_valid = 1'b0;
      bus.flush     = 1'b0;
      check("flush_accept_busy", 64'(bus.busy), 64'd0);
      issue(OP_MUL, 1'b1, 32'd2, 32'd3, "mul_after_flush");

      // MTLO presented while busy must be held off.
      issue(OP_DIV, 1'b1, 32'd100, 32'd7, "div_hold");
      @(negedge clock);
      bus.req_valid = 1'b1;
      bus.req_op    = OP_MTLO;
      bus.a         = 32'hDEAD_BEEF;
      for (int i = 0; i < 3; i++) begin
         check("hold_ready", 64'(bus.req_ready), 64'd0);
         @(negedge clock);
      end
      bus.req_valid = 1'b0;
      check("hold_lo", 64'(bus.lo), 64'd6);
      drain();

      for (int i = 0; i < 40; i++) begin
         muldiv_op_t   op;
         logic [W-1:0] ra, rb;
         op = muldiv_op_t'($urandom_range(0, 5));
         ra = pick();
         rb = pick();
         issue(op, 1'($urandom), ra, rb, $sformatf("rnd%0d", i));
      end
      drain();

      // Asynchronous reset in the middle of a DIV.
      issue(OP_DIV, 1'b1, 32'd5, 32'd0, "div_rst");
      repeat (5) @(negedge clock);
      check("pre_rst_dbz", 64'(bus.div_by_zero), 64'd1);
      #2;
      reset_n = 1'b0;
      #1;
      check("arst_hi", 64'(bus.hi), 64'd0);
      check("arst_lo", 64'(bus.lo), 64'd0);
      check("arst_busy", 64'(bus.busy), 64'd0);
      check("arst_done", 64'(bus.done), 64'd0);
      check("arst_dbz", 64'(bus.div_by_zero), 64'd0);
      exp_q.delete();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
